// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: runs one descriptor as a full I2C register write/read over the bridge I2C_DATA slot.
// Ports: clk, rst (sync, active-high); go/op/dev_addr/reg_addr/len_m1/wdata descriptor in;
//   busy/done/err/rdata result out; br_data_in/br_data_wr/br_data_rd to the bridge, br_data_out status from it.
// Optional: define I2C_SEQ_TIMEOUT_EN for a per-wait watchdog of TIMEOUT_CYCLES cycles (err=10).
module i2c_reg_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMO_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        op,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [1:0]  len_m1,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic [31:0] br_data_in,
    output logic        br_data_wr,
    output logic        br_data_rd,
    input  logic [31:0] br_data_out
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WAIT_TX, S_DATA, S_WAIT_IDLE, S_RCMD, S_WAIT_RX, S_RACK, S_DONE
    } state_t;
    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  k_q, k_d;
    logic [1:0]  idx_q, idx_d;
    logic        rph_q, rph_d;
    logic        settle_q, settle_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] bin_q, bin_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [2:0]  last;
    logic [31:0] wsh;
    logic [7:0]  dbyte;
    logic        in_wait;
    logic        sample;
    logic        unused_hi;

    function automatic logic [31:0] rcmd(input logic [1:0] i, input logic [1:0] l, input logic [6:0] d);
        return {19'd0, i == l, 2'b00, 1'b1, i == 2'd0, i == 2'd0 ? {1'b0, d} : 8'd0};
    endfunction

    // k counts DATA bytes already issued; byte 0 of the stream is always reg_addr
    assign last      = op_q ? 3'd0 : {1'b0, len_q} + 3'd1;
    assign wsh       = wdata_q >> {k_q - 3'd1, 3'd0};
    assign dbyte     = (k_q == 3'd0) ? reg_q : wsh[7:0];
    assign in_wait   = state_q inside {S_WAIT_TX, S_WAIT_IDLE, S_WAIT_RX};
    // the first wait cycle after a strobe is a settle cycle: bridge status lags by one
    assign sample    = in_wait && !settle_q;
    assign unused_hi = ^br_data_out[31:12];

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             to_q, to_d;
    assign err = {to_q, nack_q & ~to_q};
`else
    localparam int unused_tmo = TIMEOUT_CYCLES + TMO_W;
    assign err = {1'b0, nack_q};
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        k_d      = k_q;
        idx_d    = idx_q;
        rph_d    = rph_q;
        settle_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        nack_d   = nack_q;
        rdata_d  = rdata_q;
        bin_d    = '0;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        to_d     = to_q;
`endif
        case (state_q)
            S_IDLE: if (go) begin
                state_d = S_ADDR;
                op_d    = op;
                dev_d   = dev_addr;
                reg_d   = reg_addr;
                len_d   = len_m1;
                wdata_d = wdata;
                k_d     = '0;
                idx_d   = '0;
                rph_d   = 1'b0;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
                rdata_d = '0;
                wr_d    = 1'b1;
                bin_d   = {19'd0, 5'b01001, 1'b0, dev_addr};
`ifdef I2C_SEQ_TIMEOUT_EN
                to_d    = 1'b0;
`endif
            end
            S_ADDR, S_DATA: begin
                state_d  = S_WAIT_TX;
                settle_d = 1'b1;
            end
            S_RCMD: begin
                state_d  = S_WAIT_RX;
                settle_d = 1'b1;
            end
            S_WAIT_TX: if (sample && !br_data_out[11]) begin
                if (k_q > last) state_d = S_WAIT_IDLE;
                else begin
                    state_d = S_DATA;
                    wr_d    = 1'b1;
                    k_d     = k_q + 3'd1;
                    bin_d   = {19'd0, k_q == last, 4'b0100, dbyte};
                end
            end
            S_WAIT_IDLE: if (sample && !br_data_out[9]) begin
                if (op_q && !rph_q) begin
                    state_d = S_RCMD;
                    rph_d   = 1'b1;
                    wr_d    = 1'b1;
                    bin_d   = rcmd(2'd0, len_q, dev_q);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_WAIT_RX: if (sample && br_data_out[10]) begin
                state_d = S_RACK;
                rd_d    = 1'b1;
            end
            S_RACK: begin
                rdata_d[{idx_q, 3'd0} +: 8] = br_data_out[7:0];
                if (idx_q == len_q) begin
                    state_d  = S_WAIT_IDLE;
                    settle_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_RCMD;
                    wr_d    = 1'b1;
                    bin_d   = rcmd(idx_q + 2'd1, len_q, dev_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (sample && br_data_out[8]) nack_d = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
        tmo_d = (state_d != state_q) ? '0 : tmo_q + TMO_W'(1);
        // a satisfied wait wins over a timeout landing on the same cycle
        if (in_wait && state_d == state_q && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            to_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            rph_q    <= 1'b0;
            settle_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            rdata_q  <= '0;
            bin_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            len_q    <= len_d;
            wdata_q  <= wdata_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            rph_q    <= rph_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            rdata_q  <= rdata_d;
            bin_q    <= bin_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
            to_q     <= to_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign br_data_in = bin_q;
    assign br_data_wr = wr_q;
    assign br_data_rd = rd_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed bench with a bridge/slave responder and a transaction-level expectation model.
module tb_i2c_reg_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        op = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [7:0]  reg_addr = '0;
    logic [1:0]  len_m1 = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, br_data_wr, br_data_rd;
    logic [1:0]  err;
    logic [31:0] rdata, br_data_in, br_data_out;
    int total = 0, bad = 0, cyc = 0, t_addr = 0, t_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(64), .TMO_W(20)) dut (
        .clk(clk), .rst(rst), .go(go), .op(op), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .len_m1(len_m1), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .br_data_in(br_data_in), .br_data_wr(br_data_wr), .br_data_rd(br_data_rd),
        .br_data_out(br_data_out)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // bridge + slave responder: each command takes 3 cycles on the bus
    logic tx_pend = 0, rx_v = 0, bbusy = 0, mack = 0, nack_addr = 0, stuck_tx = 0;
    logic [7:0]  rx_d = 0;
    logic [31:0] cur_w = 0;
    int          tx_cnt = 0;
    logic [7:0]  slave_q[$];
    assign br_data_out = {20'd0, tx_pend, rx_v, bbusy, mack, rx_d};

    always @(posedge clk) begin
        if (rst) begin
            tx_pend <= 0; rx_v <= 0; bbusy <= 0; mack <= 0; tx_cnt <= 0;
        end else if (br_data_wr) begin
            tx_pend <= 1; bbusy <= 1; tx_cnt <= 3; cur_w <= br_data_in;
            if (br_data_in[8]) mack <= 0;
        end else begin
            if (br_data_rd) rx_v <= 0;
            if (tx_cnt > 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) begin
                    if (!stuck_tx) tx_pend <= 0;
                    if (cur_w[12]) bbusy <= 0;
                    if (cur_w[8] && !cur_w[9] && nack_addr) mack <= 1;
                    if (cur_w[9] && slave_q.size() > 0) begin
                        rx_v <= 1;
                        rx_d <= slave_q.pop_front();
                    end
                end
            end
        end
    end

    // expectation model: the bridge word stream, read-back and result implied by a descriptor
    logic [31:0] exp_q[$];
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int exp_rd = 0, rd_cnt = 0, done_cnt = 0;
    logic chk_en = 0;

    task automatic prep(input bit rd, input logic [6:0] d, input logic [7:0] r, input logic [1:0] l,
                        input logic [31:0] w, input logic [31:0] sl, input bit na);
        exp_q.delete();
        slave_q.delete();
        exp_rdata = 0;
        exp_rd = 0;
        exp_q.push_back(32'h900 + {25'd0, d});
        if (!rd) begin
            exp_q.push_back(32'h400 + {24'd0, r});
            for (int i = 0; i <= int'(l); i++)
                exp_q.push_back(32'h400 + ((w >> (8 * i)) & 32'hFF) + (i == int'(l) ? 32'h1000 : 32'h0));
        end else begin
            exp_q.push_back(32'h1400 + {24'd0, r});
            for (int i = 0; i <= int'(l); i++) begin
                exp_q.push_back(32'h200 + (i == 0 ? 32'h100 + {25'd0, d} : 32'h0) + (i == int'(l) ? 32'h1000 : 32'h0));
                exp_rdata |= ((sl >> (8 * i)) & 32'hFF) << (8 * i);
                slave_q.push_back(8'((sl >> (8 * i)) & 32'hFF));
            end
            exp_rd = int'(l) + 1;
        end
        exp_err = na ? 2'b01 : 2'b00;
        nack_addr = na;
        rd_cnt = 0;
        done_cnt = 0;
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("strobe_overlap", {31'd0, br_data_wr & br_data_rd}, 0);
            if (!br_data_wr) chk("idle_data_in", br_data_in, 0);
            else if (exp_q.size() == 0) chk("unexpected_write", br_data_in, 32'hFFFF_FFFF);
            else chk("bridge_word", br_data_in, exp_q.pop_front());
            if (br_data_rd) rd_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_err", {30'd0, err}, {30'd0, exp_err});
                chk("done_rdata", rdata, exp_rdata);
                chk("done_busy", {31'd0, busy}, 0);
                chk("done_words_left", exp_q.size(), 0);
                chk("done_rd_pulses", rd_cnt, exp_rd);
            end
        end
    end

    task automatic start(input bit o, input logic [6:0] d, input logic [7:0] r, input logic [1:0] l,
                         input logic [31:0] w);
        @(negedge clk);
        op = o; dev_addr = d; reg_addr = r; len_m1 = l; wdata = w; go = 1;
        @(negedge clk);
        go = 0;
        t_addr = cyc;
        chk("go_busy", {31'd0, busy}, 1);
        chk("go_addr_strobe", {31'd0, br_data_wr}, 1);
    endtask

    task automatic wait_done(input bit go_at_done);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 1);
        t_done = cyc;
        if (go_at_done) begin
            op = 0; dev_addr = 7'h12; reg_addr = 8'h34; len_m1 = 0; go = 1;
        end
        @(negedge clk);
        go = 0;
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_after_done", {31'd0, busy}, 0);
        if (go_at_done) begin
            repeat (6) @(negedge clk);
            chk("go_at_done_ignored", {31'd0, busy}, 0);
        end
        chk("done_count", done_cnt, 1);
    endtask

    logic [31:0] lit1[4] = '{32'h0093C, 32'h00410, 32'h004AA, 32'h014BB};
    logic [31:0] lit2[5] = '{32'h00950, 32'h01402, 32'h00350, 32'h00200, 32'h01200};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {30'd0, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_data_in", br_data_in, 0);
        chk("rst_wr", {31'd0, br_data_wr}, 0);
        chk("rst_rd", {31'd0, br_data_rd}, 0);
        rst = 0;

        prep(0, 7'h3C, 8'h10, 2'd1, 32'h0000BBAA, 0, 0);
        for (int i = 0; i < 4; i++) chk("model_wr_lit", exp_q[i], lit1[i]);
        start(0, 7'h3C, 8'h10, 2'd1, 32'h0000BBAA);
        wait_done(0);

        prep(1, 7'h50, 8'h02, 2'd2, 0, 32'h00332211, 0);
        for (int i = 0; i < 5; i++) chk("model_rd_lit", exp_q[i], lit2[i]);
        chk("model_rdata_lit", exp_rdata, 32'h00332211);
        start(1, 7'h50, 8'h02, 2'd2, 0);
        wait_done(0);
        chk("rd_rdata_lit", rdata, 32'h00332211);
        chk("rd_pulses_lit", rd_cnt, 3);

        prep(0, 7'h21, 8'h05, 2'd0, 32'h00000077, 0, 1);
        start(0, 7'h21, 8'h05, 2'd0, 32'h00000077);
        wait_done(0);
        chk("nack_err_lit", {30'd0, err}, 32'h1);

        prep(0, 7'h7F, 8'hFF, 2'd3, 32'hDEADBEEF, 0, 0);
        start(0, 7'h7F, 8'hFF, 2'd3, 32'hDEADBEEF);
        wait_done(1);

        prep(1, 7'h11, 8'h80, 2'd3, 0, 32'hA5C30F01, 0);
        start(1, 7'h11, 8'h80, 2'd3, 0);
        repeat (12) @(negedge clk);
        op = 0; dev_addr = 7'h66; reg_addr = 8'h77; len_m1 = 0; wdata = 32'h55; go = 1;
        @(negedge clk);
        go = 0;
        wait_done(0);
        chk("midgo_rdata_lit", rdata, 32'hA5C30F01);

        prep(1, 7'h2A, 8'h33, 2'd1, 0, 32'h0000005A, 0);
        slave_q.delete();
        slave_q.push_back(8'h5A);
        start(1, 7'h2A, 8'h33, 2'd1, 0);
        begin
            int n = 0, rc = 0;
            while (rc < 2 && n < 400) begin
                @(negedge clk);
                n++;
                if (br_data_wr && br_data_in[9]) rc++;
            end
            chk("rst_test_rcmds", rc, 2);
        end
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        chk("pre_rst_rdata", rdata, 32'h5A);
        chk_en = 0;
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_wr", {31'd0, br_data_wr}, 0);
        chk("midrst_rd", {31'd0, br_data_rd}, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_data_in", br_data_in, 0);
        chk("midrst_done", {31'd0, done}, 0);
        rst = 0;

        prep(0, 7'h08, 8'hC0, 2'd2, 32'h00302010, 0, 0);
        start(0, 7'h08, 8'hC0, 2'd2, 32'h00302010);
        wait_done(0);

`ifdef I2C_SEQ_TIMEOUT_EN
        stuck_tx = 1;
        prep(0, 7'h44, 8'h01, 2'd0, 32'h99, 0, 0);
        exp_q.delete();
        exp_q.push_back(32'h944);
        exp_err = 2'b10;
        start(0, 7'h44, 8'h01, 2'd0, 32'h99);
        wait_done(0);
        chk("tmo_latency", t_done - t_addr, 65);
        chk("tmo_err_lit", {30'd0, err}, 32'h2);
        stuck_tx = 0;
        chk_en = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
